// File: rtl/tdm_1_8demux_if.sv
// tdm_1_8demux_if
//   Bundles the serial TDM input and the parallel frame output of the
//   1-to-8 demultiplexer.
//   master : the upstream mux / stimulus side. It drives din, din_en and fsync,
//            and it observes y, y_valid, slot and frame_err.
//   slave  : the demultiplexer itself.
//   Signals:
//     din       serial data bit, meaningful only when din_en=1
//     din_en    qualifier: din carries a slot bit this cycle
//     fsync     frame sync; marks the current qualified bit as slot 0
//     y         last completed frame (8 bits)
//     y_valid   one-cycle pulse when y is updated
//     slot      index that the next qualified bit will occupy
//     frame_err one-cycle pulse on a framing violation
interface tdm_1_8demux_if;
    logic       din;
    logic       din_en;
    logic       fsync;
    logic [7:0] y;
    logic       y_valid;
    logic [2:0] slot;
    logic       frame_err;

    modport master (
        output din, din_en, fsync,
        input  y, y_valid, slot, frame_err
    );

    modport slave (
        input  din, din_en, fsync,
        output y, y_valid, slot, frame_err
    );
endinterface

// File: rtl/tdm_1_8demux.sv
// tdm_1_8demux
//   Receiving end of the 8:1 channel-select path. The block takes a serial
//   stream that carries one bit per qualified slot, with eight slots per frame
//   and fsync on slot 0. It rebuilds the parallel 8-bit channel word and
//   publishes each completed frame in a single registered update. It also
//   flags framing violations: a lost sync, or a sync that arrives early.
//   Parameters:
//     LSB_FIRST  1: slot k lands in y[k]; 0: slot k lands in y[7-k]
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    tdm_1_8demux_if.slave (din/din_en/fsync in; y/y_valid/slot/frame_err out)
module tdm_1_8demux #(
    parameter bit LSB_FIRST = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    tdm_1_8demux_if.slave bus
);

    typedef enum logic {
        HUNT,
        RECV
    } state_t;

    state_t     state;
    logic [2:0] slot_q;
    logic [7:0] shadow;
    logic [7:0] y_q;
    logic       y_valid_q;
    logic       frame_err_q;

    logic [7:0] shadow_next;  // shadow with the current bit placed in its lane
    logic [7:0] start_word;   // fresh frame holding only the slot-0 bit

    // Bit position for a given slot. For 3 bits, 7-k is the same as ~k.
    function automatic logic [2:0] lane(input logic [2:0] k);
        return LSB_FIRST ? k : ~k;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch can be inferred.
        shadow_next               = shadow;
        shadow_next[lane(slot_q)] = bus.din;
        start_word                = '0;
        start_word[lane(3'd0)]    = bus.din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot_q      <= '0;
            shadow      <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; the later
            // assignments in this block override these pulse defaults.
            y_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;

            // Cycles without din_en leave all state alone, so gaps of any
            // length between slots are harmless.
            if (bus.din_en) begin
                unique case (state)
                    HUNT: begin
                        // Bits that arrive before the first sync are dropped silently.
                        if (bus.fsync) begin
                            shadow <= start_word;
                            slot_q <= 3'd1;
                            state  <= RECV;
                        end
                    end

                    RECV: begin
                        if (bus.fsync) begin
                            // A sync at slot 0 is the normal back-to-back start.
                            // At any other slot it is early: the partial frame is
                            // dropped and the current bit opens a new frame.
                            if (slot_q != 3'd0) begin
                                frame_err_q <= 1'b1;
                            end
                            shadow <= start_word;
                            slot_q <= 3'd1;
                        end else if (slot_q == 3'd0) begin
                            // A slot-0 bit without sync means alignment is lost.
                            frame_err_q <= 1'b1;
                            slot_q      <= 3'd0;
                            state       <= HUNT;
                        end else if (slot_q == 3'd7) begin
                            y_q       <= shadow_next;
                            y_valid_q <= 1'b1;
                            shadow    <= shadow_next;
                            slot_q    <= 3'd0;
                        end else begin
                            shadow <= shadow_next;
                            slot_q <= slot_q + 3'd1;
                        end
                    end

                    default: begin
                        state  <= HUNT;
                        slot_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.y         = y_q;
    assign bus.y_valid   = y_valid_q;
    assign bus.slot      = slot_q;
    assign bus.frame_err = frame_err_q;

endmodule
